sdr_port_arbiter: RTL

//  Shares the single line-transfer port of the SDRAM controller between two

---
 rtl/sdr_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sdr_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdr_port_arbiter
//
// Purpose:
//   Shares the single line-transfer port of the SDRAM controller between two
//   requesters. Port 0 is the video line prefetcher. Port 1 is the CPU cache.
//   The arbiter runs one burst transaction at a time. While a burst is running
//   it steers the controller's per-word get/put strobes and the write data to
//   the port that owns the burst. The whole block runs in the SDRAM clock
//   domain.
//
// Parameters:
//   AW         line address width
//   DW         data word width
//   BURST_LEN  words per transaction (power of 2, 2..64)
//
// Configuration macro:
//   ARB_PRIO0_EN  When defined, port 0 has strict priority. A starvation guard
//                 grants port 1 once after four consecutive port-0 grants that
//                 were made while port 1 was waiting.
//                 When undefined, the arbiter is pure round-robin and no
//                 starvation counter is built.
//
// Ports:
//   clk, rst               clock; synchronous active-low reset
//   rN_addr/rd/wr/wdata    requester N inputs (N = 0,1); rd/wr are levels
//                          that are held until rN_done
//   rN_rdata/get/put/done  requester N outputs; done is a one-cycle pulse
//   m_addr/rd/wr/wdata     command and write data to the controller
//   m_rdata/get/put        read data and per-word strobes from the controller
//   busy                   a transaction is in progress
//   owner                  index of the granted port; holds its value after
//                          the burst ends
//   err                    sticky protocol-violation flag
// -----------------------------------------------------------------------------
module sdr_port_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int BURST_LEN = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] r0_addr,
    input  logic          r0_rd,
    input  logic          r0_wr,
    input  logic [DW-1:0] r0_wdata,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_get,
    output logic          r0_put,
    output logic          r0_done,

    input  logic [AW-1:0] r1_addr,
    input  logic          r1_rd,
    input  logic          r1_wr,
    input  logic [DW-1:0] r1_wdata,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_get,
    output logic          r1_put,
    output logic          r1_done,

    output logic [AW-1:0] m_addr,
    output logic          m_rd,
    output logic          m_wr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_get,
    input  logic          m_put,

    output logic          busy,
    output logic          owner,
    output logic          err
);

    // The extra bit lets the counter reach BURST_LEN without wrapping.
    localparam int            CW   = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic            owner_q,   owner_d;
    logic            rr_last_q, rr_last_d;
    logic            err_q,     err_d;
    logic            m_rd_q,    m_rd_d;
    logic            m_wr_q,    m_wr_d;
    logic [AW-1:0]   m_addr_q,  m_addr_d;
    logic            busy_q,    busy_d;
    logic            done0_q,   done0_d;
    logic            done1_q,   done1_d;

    logic            req0;
    logic            req1;
    logic            grant_idx;
    logic            grant_wr;
    logic [AW-1:0]   grant_addr;
    logic            in_xfer;
    logic            strobe_ok;
    logic            protocol_bad;

    assign req0 = r0_rd | r0_wr;
    assign req1 = r1_rd | r1_wr;

`ifdef ARB_PRIO0_EN
    // Number of consecutive port-0 grants made while port 1 was waiting.
    logic [2:0] starve_q, starve_d;

    always_comb begin
        grant_idx = 1'b0;
        if (req1 && (!req0 || starve_q == 3'd4)) begin
            grant_idx = 1'b1;
        end
    end
`else
    // On a tie, the port that was not granted last time wins.
    always_comb begin
        grant_idx = 1'b0;
        if (req0 && req1) begin
            grant_idx = ~rr_last_q;
        end else begin
            grant_idx = req1;
        end
    end
`endif

    // A write wins over a read on the same port, so a write-back is done
    // before the fill.
    assign grant_wr   = grant_idx ? r1_wr   : r0_wr;
    assign grant_addr = grant_idx ? r1_addr : r0_addr;

    assign in_xfer = (state_q == ST_XFER);

    // Only a strobe that matches the command counts. If get and put arrive
    // together, exactly one of them matches, so the word is counted once.
    assign strobe_ok = in_xfer & ((m_rd_q & m_put) | (m_wr_q & m_get));

    // A strobe outside a burst, or a strobe in the wrong direction, is a
    // violation.
    assign protocol_bad = in_xfer ? ((m_rd_q & m_get) | (m_wr_q & m_put))
                                  : (m_get | m_put);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        err_d     = err_q | protocol_bad;
        m_rd_d    = m_rd_q;
        m_wr_d    = m_wr_q;
        m_addr_d  = m_addr_q;
        busy_d    = busy_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
`ifdef ARB_PRIO0_EN
        starve_d  = starve_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d   = ST_XFER;
                    owner_d   = grant_idx;
                    rr_last_d = grant_idx;
                    m_addr_d  = grant_addr;
                    m_wr_d    = grant_wr;
                    m_rd_d    = ~grant_wr;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
`ifdef ARB_PRIO0_EN
                    if (grant_idx) begin
                        starve_d = 3'd0;
                    end else if (req1) begin
                        starve_d = starve_q + 3'd1;
                    end else begin
                        starve_d = 3'd0;
                    end
`endif
                end
            end
            ST_XFER: begin
                // The requester's rd/wr are not looked at here. Once a burst
                // has been granted, it always runs to completion.
                if (strobe_ok) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = ST_DONE;
                        m_rd_d  = 1'b0;
                        m_wr_d  = 1'b0;
                        busy_d  = 1'b0;
                        done0_d = ~owner_q;
                        done1_d = owner_q;
                    end
                end
            end
            ST_DONE: begin
                // This forces at least one idle cycle between bursts.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            err_q     <= 1'b0;
            m_rd_q    <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            busy_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
`ifdef ARB_PRIO0_EN
            starve_q  <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
            m_rd_q    <= m_rd_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            busy_q    <= busy_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
`ifdef ARB_PRIO0_EN
            starve_q  <= starve_d;
`endif
        end
    end

    // Data path steering. Read data goes to both ports without
    // qualification. Each port uses its own put strobe to know when the data
    // is valid.
    assign m_wdata  = owner_q ? r1_wdata : r0_wdata;
    assign r0_rdata = m_rdata;
    assign r1_rdata = m_rdata;
    assign r0_get   = m_get & in_xfer & ~owner_q;
    assign r1_get   = m_get & in_xfer &  owner_q;
    assign r0_put   = m_put & in_xfer & ~owner_q;
    assign r1_put   = m_put & in_xfer &  owner_q;

    assign r0_done  = done0_q;
    assign r1_done  = done1_q;
    assign m_addr   = m_addr_q;
    assign m_rd     = m_rd_q;
    assign m_wr     = m_wr_q;
    assign busy     = busy_q;
    assign owner    = owner_q;
    assign err      = err_q;

endmodule
